// File: rtl/fnd_display_scheduler.sv
// Arbitrates the 4-digit FND between coffee animation, internal status messages and balance display.
// Optional MSG_BLINK_EN: blink the status message with a BLINK_MS half-period.
module fnd_display_scheduler #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int MSG_HOLD_MS = 1000,
    parameter int BLINK_MS    = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       anim_req,
    input  logic [7:0] anim_seg,
    input  logic [3:0] anim_an,
    input  logic [7:0] bal_seg,
    input  logic [3:0] bal_an,
    input  logic       msg_req,
    input  logic [1:0] msg_code,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic [1:0] active_src,
    output logic       msg_busy
);
    localparam int TICK_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W   = $clog2(MSG_HOLD_MS + 1);

    typedef enum logic [1:0] {S_BAL = 2'd0, S_MSG = 2'd1, S_ANIM = 2'd2} state_t;

    state_t            state, next_state;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [1:0]        code_q;
    logic [HOLD_W-1:0] msg_left;
    logic [1:0]        scan_idx;
    logic              blink_off;

    function automatic logic [7:0] msg_glyph(input logic [1:0] code, input logic [1:0] idx);
        logic [7:0] g;
        g = 8'hFF;
        case (code)
            2'd0: case (idx)
                2'd0: g = 8'h86;
                2'd1: g = 8'hAF;
                2'd2: g = 8'hAF;
                default: g = 8'hBF;
            endcase
            2'd1: case (idx)
                2'd0: g = 8'hA1;
                2'd1: g = 8'hA3;
                2'd2: g = 8'hAB;
                default: g = 8'h86;
            endcase
            2'd2: g = 8'hBF;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    function automatic logic [3:0] digit_an(input logic [1:0] idx);
        return ~(4'b1000 >> idx);
    endfunction

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else tick_cnt <= tick_cnt + 1'b1;
    end

    // Hold timer freezes during animation; a new request always restarts from the leftmost digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q   <= 2'd0;
            msg_left <= '0;
            msg_busy <= 1'b0;
            scan_idx <= 2'd0;
        end else if (msg_req) begin
            code_q   <= msg_code;
            msg_left <= HOLD_W'(MSG_HOLD_MS);
            msg_busy <= 1'b1;
            scan_idx <= 2'd0;
        end else begin
            if (msg_busy && tick && !anim_req) begin
                msg_left <= msg_left - 1'b1;
                if (msg_left == HOLD_W'(1)) msg_busy <= 1'b0;
            end
            if (state == S_MSG && tick) scan_idx <= scan_idx + 2'd1;
        end
    end

`ifdef MSG_BLINK_EN
    localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    logic [BLINK_W-1:0] blink_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (msg_req) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (state == S_MSG && tick && !anim_req) begin
            if (blink_cnt == BLINK_W'(BLINK_MS - 1)) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    assign blink_off = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            S_BAL:  if (anim_req) next_state = S_ANIM;
                    else if (msg_busy) next_state = S_MSG;
            S_MSG:  if (anim_req) next_state = S_ANIM;
                    else if (!msg_busy) next_state = S_BAL;
            S_ANIM: if (!anim_req) next_state = msg_busy ? S_MSG : S_BAL;
            default: next_state = S_BAL;
        endcase
    end

    // Any source switch costs one blank cycle so the old digit never ghosts onto the new source.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_BAL;
            active_src <= 2'd0;
            seg        <= 8'hFF;
            an         <= 4'b1111;
        end else begin
            state      <= next_state;
            active_src <= next_state;
            if (next_state != state) begin
                seg <= 8'hFF;
                an  <= 4'b1111;
            end else begin
                case (state)
                    S_ANIM: begin
                        seg <= anim_seg;
                        an  <= anim_an;
                    end
                    S_MSG: begin
                        seg <= blink_off ? 8'hFF : msg_glyph(code_q, scan_idx);
                        an  <= blink_off ? 4'b1111 : digit_an(scan_idx);
                    end
                    default: begin
                        seg <= bal_seg;
                        an  <= bal_an;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Randomized bench for fnd_display_scheduler with a per-cycle behavioural model (tick every clock).
module tb_fnd_display_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic       anim_req, msg_req;
    logic [7:0] anim_seg, bal_seg;
    logic [3:0] anim_an, bal_an;
    logic [1:0] msg_code;
    logic [7:0] seg;
    logic [3:0] an;
    logic [1:0] active_src;
    logic       msg_busy;
    logic [14:0] dut_out;

    int compared   = 0;
    int mismatched = 0;

    // model state
    int m_src, m_busy, m_left, m_code, m_digit;
`ifdef MSG_BLINK_EN
    int m_blink_cnt, m_blink_off;
`endif
    logic [14:0] exp_out;
    logic [7:0] rom [0:3][0:3] = '{'{8'h86, 8'hAF, 8'hAF, 8'hBF},
                                   '{8'hA1, 8'hA3, 8'hAB, 8'h86},
                                   '{4{8'hBF}},
                                   '{4{8'hFF}}};

    always #5 clk = ~clk;

    assign dut_out = {seg, an, active_src, msg_busy};

    fnd_display_scheduler #(.CLK_HZ(1000), .MSG_HOLD_MS(5), .BLINK_MS(2)) dut (
        .clk(clk), .reset(reset), .anim_req(anim_req), .anim_seg(anim_seg), .anim_an(anim_an),
        .bal_seg(bal_seg), .bal_an(bal_an), .msg_req(msg_req), .msg_code(msg_code),
        .seg(seg), .an(an), .active_src(active_src), .msg_busy(msg_busy)
    );

    task automatic model_reset();
        m_src = 0; m_busy = 0; m_left = 0; m_code = 0; m_digit = 0;
`ifdef MSG_BLINK_EN
        m_blink_cnt = 0; m_blink_off = 0;
`endif
        exp_out = {8'hFF, 4'hF, 2'd0, 1'b0};
    endtask

    // Advance model by one clock using the inputs presently applied, then clock the DUT.
    task automatic step();
        int want;
        logic [7:0] es;
        logic [3:0] ea;
        want = anim_req ? 2 : (m_busy != 0 ? 1 : 0);
        if (want != m_src) begin
            es = 8'hFF; ea = 4'hF;
        end else if (m_src == 2) begin
            es = anim_seg; ea = anim_an;
        end else if (m_src == 0) begin
            es = bal_seg; ea = bal_an;
        end else begin
            es = rom[m_code][m_digit];
            ea = 4'hF;
            ea[3 - m_digit] = 1'b0;
`ifdef MSG_BLINK_EN
            if (m_blink_off != 0) begin es = 8'hFF; ea = 4'hF; end
`endif
        end
        if (msg_req) begin
            m_code = int'(msg_code); m_left = 5; m_busy = 1; m_digit = 0;
`ifdef MSG_BLINK_EN
            m_blink_cnt = 0; m_blink_off = 0;
`endif
        end else begin
            if (m_src == 1) m_digit = (m_digit + 1) % 4;
`ifdef MSG_BLINK_EN
            if (m_src == 1 && !anim_req) begin
                m_blink_cnt++;
                if (m_blink_cnt == 2) begin m_blink_cnt = 0; m_blink_off = 1 - m_blink_off; end
            end
`endif
            if (m_busy != 0 && !anim_req) begin
                m_left--;
                if (m_left == 0) m_busy = 0;
            end
        end
        m_src = want;
        exp_out = {es, ea, 2'(want), 1'(m_busy)};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; anim_req = 0; msg_req = 0; msg_code = 0;
        anim_seg = 8'hFF; anim_an = 4'hF; bal_seg = 8'hFF; bal_an = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (dut_out !== 15'({8'hFF, 4'hF, 2'd0, 1'b0})) begin
            mismatched++;
            $display("FAIL reset_state: got %h want %h", dut_out, 15'({8'hFF, 4'hF, 2'd0, 1'b0}));
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_balance();
        for (int i = 0; i < 8; i++) begin
            bal_seg = (i == 0) ? 8'hC0 : 8'($urandom);
            bal_an  = (i == 0) ? 4'b1110 : 4'($urandom);
            step();
            compared++;
            if (dut_out !== exp_out) begin
                mismatched++;
                $display("FAIL balance cyc %0d: got %h want %h", i, dut_out, exp_out);
            end
        end
    endtask

    task automatic test_message();
        int busy_cnt = 0;
        msg_code = 2'd0; msg_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bal_seg = 8'($urandom); bal_an = 4'($urandom);
            step();
            msg_req = 1'b0;
            if (msg_busy) busy_cnt++;
            compared++;
            if (dut_out !== exp_out) begin
                mismatched++;
                $display("FAIL message cyc %0d: got %h want %h", i, dut_out, exp_out);
            end
        end
        compared++;
        if (busy_cnt != 5) begin
            mismatched++;
            $display("FAIL message_hold: busy for %0d cycles, want 5", busy_cnt);
        end
    endtask

    task automatic test_anim_freeze();
        int busy_cnt = 0;
        int k;
        k = $urandom_range(3, 6);
        msg_code = 2'd1; msg_req = 1'b1;
        for (int i = 0; i < 3 + k + 10; i++) begin
            anim_req = (i >= 3 && i < 3 + k);
            anim_seg = 8'($urandom); anim_an = 4'($urandom);
            bal_seg = 8'($urandom); bal_an = 4'($urandom);
            step();
            msg_req = 1'b0;
            if (msg_busy) busy_cnt++;
            compared++;
            if (dut_out !== exp_out) begin
                mismatched++;
                $display("FAIL anim_freeze cyc %0d: got %h want %h", i, dut_out, exp_out);
            end
        end
        anim_req = 1'b0;
        compared++;
        if (busy_cnt != 5 + k) begin
            mismatched++;
            $display("FAIL anim_hold: busy for %0d cycles, want %0d", busy_cnt, 5 + k);
        end
    endtask

    task automatic test_back_to_back();
        int drops = 0;
        msg_code = 2'd0; msg_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            msg_req = (i == 0 || i == 3);
            if (i == 3) msg_code = 2'd1;
            step();
            compared++;
            if (dut_out !== exp_out) begin
                mismatched++;
                $display("FAIL restart cyc %0d: got %h want %h", i, dut_out, exp_out);
            end
        end
        // request lands on the same edge the hold timer expires
        for (int i = 0; i < 14; i++) begin
            msg_req = (i == 0 || i == 5);
            msg_code = (i == 0) ? 2'd2 : 2'd3;
            step();
            if (i <= 9 && !msg_busy) drops++;
            compared++;
            if (dut_out !== exp_out) begin
                mismatched++;
                $display("FAIL expiry_collide cyc %0d: got %h want %h", i, dut_out, exp_out);
            end
        end
        msg_req = 1'b0;
        compared++;
        if (drops != 0) begin
            mismatched++;
            $display("FAIL expiry_busy: msg_busy low %0d cycles, want 0", drops);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) anim_req = ~anim_req;
            msg_req  = ($urandom_range(0, 9) == 0);
            msg_code = 2'($urandom);
            anim_seg = 8'($urandom); anim_an = 4'($urandom);
            bal_seg  = 8'($urandom); bal_an  = 4'($urandom);
            step();
            compared++;
            if (dut_out !== exp_out) begin
                mismatched++;
                $display("FAIL random cyc %0d: got %h want %h", i, dut_out, exp_out);
            end
        end
        anim_req = 1'b0; msg_req = 1'b0;
    endtask

    task automatic test_reset_midrun();
        msg_code = 2'd1; msg_req = 1'b1;
        step();
        msg_req = 1'b0;
        step(); step();
        anim_req = 1'b1;
        step(); step();
        #2 reset = 1'b1;
        #1;
        compared++;
        if (dut_out !== 15'({8'hFF, 4'hF, 2'd0, 1'b0})) begin
            mismatched++;
            $display("FAIL async_reset: got %h want %h", dut_out, 15'({8'hFF, 4'hF, 2'd0, 1'b0}));
        end
        anim_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            bal_seg = 8'($urandom); bal_an = 4'($urandom);
            step();
            compared++;
            if (dut_out !== exp_out) begin
                mismatched++;
                $display("FAIL post_reset cyc %0d: got %h want %h", i, dut_out, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_balance();
        test_message();
        test_anim_freeze();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fnd_display_scheduler.md
Name: fnd_display_scheduler

Overview:
Owns the single 4-digit FND and decides which source drives it each cycle: coffee animation, a timed status message generated internally, or the balance display from fnd_controller. Priority is animation > message > balance. Sits between vending_machine_core/fnd_controller and the board seg/an pins, replacing the top-level 2:1 mux. Registered outputs, with a blanking cycle on every source switch.

Parameters:
CLK_HZ, 100_000_000, clk frequency; one ms tick every CLK_HZ/1000 cycles.
MSG_HOLD_MS, 1000, message display time in ms ticks (>=1).
BLINK_MS, 250, blink half-period in ms ticks (used only with MSG_BLINK_EN).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
anim_req  in  1  level; high while coffee is being made
anim_seg  in  8  animation pattern, active-low {dp,g,f,e,d,c,b,a}
anim_an  in  4  animation digit select, active-low
bal_seg  in  8  balance pattern from fnd_controller
bal_an  in  4  balance digit select from fnd_controller
msg_req  in  1  single-cycle pulse; start/restart message
msg_code  in  2  message select, sampled when msg_req=1
seg  out  8  FND segments, active-low
an  out  4  FND digit select, active-low
active_src  out  2  0=balance, 1=message, 2=animation
msg_busy  out  1  high while a message is pending or shown

Behaviour:
- Reset, asynchronous: seg=8'hFF, an=4'b1111, active_src=0, msg_busy=0, timers/scan counter=0, state=S_BAL.
- ms tick: free-running counter, tick high for 1 cycle every CLK_HZ/1000 clocks.
- Message ROM, an[3]=leftmost, left->right:
  - code 0 "Err-" = 86,AF,AF,BF
  - code 1 "donE" = A1,A3,AB,86
  - code 2 "----" = BF x4
  - code 3 blank = FF x4
- Message scan: 2-bit digit index advances on each tick (1 ms per digit, wraps 3->0). an one-hot low: index 0 -> an=0111 ... index 3 -> an=1110.
- Message timer:
  - msg_req loads the code, sets remaining=MSG_HOLD_MS and sets msg_busy, in any state.
  - Decrements on tick only while anim_req=0. Frozen while animation is active.
  - At 0, clears msg_busy.
  - msg_req while busy overwrites the code and restarts the timer.
  - msg_req on the same cycle the timer expires wins: msg_busy stays 1.
- States:
  - S_BAL: -> S_ANIM if anim_req; else -> S_MSG if msg_busy.
  - S_MSG: -> S_ANIM if anim_req; -> S_BAL when msg_busy falls.
  - S_ANIM: when anim_req falls -> S_MSG if msg_busy, else S_BAL.
  - Evaluated every cycle. anim_req and msg_req on the same cycle -> S_ANIM, with the message latched.
- Output path:
  - seg/an registered from the selected source; 1-cycle latency from input to pin.
  - On the cycle a state change is registered, outputs forced to seg=FF, an=1111 (one blank cycle, anti-ghosting).
  - active_src updates in the same cycle as the state.
- Reset mid-message or mid-animation: immediate blank, message discarded, S_BAL.

Optional Feature:
MSG_BLINK_EN
- Defined: in S_MSG, a blink counter toggles a phase every BLINK_MS ticks, restarted at msg_req. Phase 0 = shown, phase 1 = seg=FF, an=1111. Counter frozen along with the hold timer during animation.
- Undefined: the message is shown steadily; no blink logic is synthesised.

Test Plan:
All scenarios use CLK_HZ=1000 (tick every cycle), MSG_HOLD_MS=5, BLINK_MS=2.
1. Assert reset mid-run -> seg=FF, an=1111, active_src=0, msg_busy=0 immediately, without waiting for a clock edge.
2. Idle, bal_seg=C0, bal_an=1110 -> one blank-free cycle later seg=C0, an=1110, active_src=0.
3. msg_req with code 0 -> one blank cycle, then digits 86,AF,AF,BF on an=0111,1011,1101,1110. msg_busy falls after 5 ticks, then one blank cycle, then balance returns.
4. anim_req=1 two ticks into message code 1 -> anim_seg/anim_an pass through, active_src=2. After anim_req=0, "donE" is shown for the remaining 3 ticks, then balance.
5. msg_req code 1 at tick 3 of a code 0 message -> "donE" shown for a full 5 ticks. msg_req on the expiry cycle -> msg_busy never drops.
6. With MSG_BLINK_EN defined, message code 2 -> BF on 2 ticks, blank on 2 ticks, alternating, then balance after 5 ticks. Without the macro -> steady BF for all 5 ticks.
